fifo_uart_tx: RTL and testbench

Drains the 16-entry byte FIFO from its read side and transmits each byte as an 8N1 asynchronous serial frame. It owns the FIFO's `rd_en` and consumes the FIFO's `dout`, `empty` and `full`; the producer keeps writing through `wr_en`/`din`. A clock-divider parameter sets the bit time. The block is the consumer counterpart to the FIFO's write-side producer.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/baud_tick.sv | 30 +++
 rtl/fifo_uart_tx.sv | 137 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO-drain UART transmitter.
// Provides the FSM state encoding, data width and default bit time.
package fifo_pkg;

  localparam int DATA_W               = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_e;

endpackage

// File: rtl/baud_tick.sv
// Bit-time generator: one-cycle tick every CLKS_PER_BIT cycles.
// clk/reset: clock, async active-low reset; clear: restart bit time; tick: bit-time expired.
module baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Counts down LAST..0; tick marks the final cycle of a bit.
  assign tick = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q - CW'(1);
    if (clear || tick) cnt_d = LAST;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a byte FIFO and sends each byte as an 8N1 serial frame.
// In: clk, reset(n), enable, empty, full, wr_en_mon, fifo_dout. Out: rd_en, tx, busy, tx_done.
module fifo_uart_tx
  import fifo_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              empty,
  input  logic              full,
  input  logic              wr_en_mon,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              rd_en,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [2:0]        bit_q, bit_d;
  logic              rd_en_q, rd_en_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic tick;
  logic clear;
  logic start_ok;
  logic collide;

  assign start_ok = enable && !empty;
  // A write to a non-full FIFO wins over our pop.
  assign collide  = wr_en_mon && !full;
  assign clear    = (state_d != state_q);

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      rd_en_q <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      rd_en_q <= rd_en_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start_ok) state_d = POP;
      POP:   if (!collide) state_d = LOAD;
      LOAD:  state_d = START;
      START: if (tick) state_d = DATA;
      DATA:  if (tick && bit_q == 3'd7) state_d = STOP;
      // Re-arm straight from the stop edge so frames
      // are separated only by POP and LOAD.
      STOP:  if (tick) state_d = start_ok ? POP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_d = shift_q;
    bit_d   = bit_q;
    rd_en_d = 1'b0;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      POP: begin
        rd_en_d = collide;
      end
      LOAD: begin
        shift_d = fifo_dout;
        tx_d    = 1'b0;
      end
      START: begin
        if (tick) tx_d = shift_q[0];
      end
      DATA: begin
        if (tick) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            tx_d = 1'b1;
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (tick) begin
          done_d = 1'b1;
          if (start_ok) rd_en_d = 1'b1;
          else          busy_d  = 1'b0;
        end
      end
      default: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  assign rd_en   = rd_en_q;
  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a behavioural 16-entry FIFO.
// Bit time is 4 clocks; outputs are sampled on the falling edge.
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       wr_en;
  logic [7:0] din;
  logic       rd_en, tx, busy, tx_done;
  logic       empty, full;

  logic [7:0] mem [16];
  logic [3:0] wp = '0;
  logic [3:0] rp = '0;
  logic [4:0] cnt = '0;
  logic [7:0] dout = '0;
  int         pops = 0;

  int rd_cnt = 0, done_cnt = 0, busy_lo = 0, tx_lo = 0;
  int n_checks = 0, n_err = 0;

  always #5 clk = ~clk;

  assign empty = (cnt == 5'd0);
  assign full  = (cnt == 5'd16);

  // Write has priority over read unless the FIFO is full.
  always @(posedge clk) begin
    if (wr_en && !full) begin
      mem[wp] <= din;
      wp      <= wp + 4'd1;
      cnt     <= cnt + 5'd1;
    end else if (rd_en && !empty) begin
      dout <= mem[rp];
      rp   <= rp + 4'd1;
      cnt  <= cnt - 5'd1;
      pops <= pops + 1;
    end
  end

  always @(negedge clk) begin
    if (rd_en)   rd_cnt   <= rd_cnt + 1;
    if (tx_done) done_cnt <= done_cnt + 1;
    if (!busy)   busy_lo  <= busy_lo + 1;
    if (!tx)     tx_lo    <= tx_lo + 1;
  end

  fifo_uart_tx #(
    .CLKS_PER_BIT(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .empty    (empty),
    .full     (full),
    .wr_en_mon(wr_en),
    .fifo_dout(dout),
    .rd_en    (rd_en),
    .tx       (tx),
    .busy     (busy),
    .tx_done  (tx_done)
  );

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    wr_en = 1'b1;
    din   = b;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Waits for a start bit, then captures 10 bits of 4 samples each.
  task automatic rx_frame(input int budget, output int lat,
                          output logic [9:0] bits, output bit stable);
    lat    = -1;
    bits   = '1;
    stable = 1'b1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) return;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 4; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (c == 0) bits[b] = tx;
        else if (tx !== bits[b]) stable = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (rd_en !== 1'b0) begin
      n_err++; $display("FAIL reset_rd_en got=%b exp=0", rd_en);
    end
    n_checks++;
    if (tx !== 1'b1) begin
      n_err++; $display("FAIL reset_tx got=%b exp=1", tx);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL reset_busy got=%b exp=0", busy);
    end
    n_checks++;
    if (tx_done !== 1'b0) begin
      n_err++; $display("FAIL reset_tx_done got=%b exp=0", tx_done);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int lat, r0, d0, p0;
    logic [9:0] bits, exp;
    bit st;
    exp = {1'b1, 8'hA5, 1'b0};
    push(8'hA5);
    r0 = rd_cnt; d0 = done_cnt; p0 = pops;
    enable = 1'b1;
    rx_frame(20, lat, bits, st);
    n_checks++;
    if (lat !== 3) begin
      n_err++; $display("FAIL single_latency got=%0d exp=3", lat);
    end
    n_checks++;
    if (bits !== exp) begin
      n_err++; $display("FAIL single_bits got=%b exp=%b", bits, exp);
    end
    n_checks++;
    if (st !== 1'b1) begin
      n_err++; $display("FAIL single_bit_width got=%b exp=1", st);
    end
    @(negedge clk);
    n_checks++;
    if (tx_done !== 1'b1) begin
      n_err++; $display("FAIL single_tx_done got=%b exp=1", tx_done);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL single_busy_end got=%b exp=0", busy);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (rd_cnt - r0 !== 1) begin
      n_err++; $display("FAIL single_rd_cycles got=%0d exp=1", rd_cnt - r0);
    end
    n_checks++;
    if (done_cnt - d0 !== 1) begin
      n_err++; $display("FAIL single_done_pulses got=%0d exp=1", done_cnt - d0);
    end
    n_checks++;
    if (pops - p0 !== 1 || empty !== 1'b1) begin
      n_err++;
      $display("FAIL single_pop got=%0d empty=%b exp=1 empty=1", pops - p0, empty);
    end
    enable = 1'b0;
  endtask

  task automatic test_burst();
    int lat, r0, d0, b0;
    logic [9:0] bits, exp;
    bit st;
    push(8'h01); push(8'h02); push(8'h03);
    r0 = rd_cnt; d0 = done_cnt; b0 = 0;
    enable = 1'b1;
    for (int f = 0; f < 3; f++) begin
      exp = {1'b1, 8'(f + 1), 1'b0};
      rx_frame(20, lat, bits, st);
      if (f == 0) b0 = busy_lo;
      n_checks++;
      if (lat !== 3) begin
        n_err++; $display("FAIL burst_gap%0d got=%0d exp=3", f, lat);
      end
      n_checks++;
      if (bits !== exp) begin
        n_err++; $display("FAIL burst_bits%0d got=%b exp=%b", f, bits, exp);
      end
    end
    n_checks++;
    if (busy_lo - b0 !== 0) begin
      n_err++; $display("FAIL burst_busy_hold got=%0d exp=0", busy_lo - b0);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || tx_done !== 1'b1) begin
      n_err++;
      $display("FAIL burst_end got busy=%b done=%b exp busy=0 done=1", busy, tx_done);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (done_cnt - d0 !== 3 || rd_cnt - r0 !== 3) begin
      n_err++;
      $display("FAIL burst_counts got done=%0d rd=%0d exp 3 3", done_cnt - d0, rd_cnt - r0);
    end
    enable = 1'b0;
  endtask

  task automatic test_collision();
    int lat, r0, p0;
    logic [9:0] bits, exp;
    bit st;
    push(8'h3C);
    r0 = rd_cnt; p0 = pops;
    enable = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rd_en !== 1'b1) begin
      n_err++; $display("FAIL coll_pop_rd_en got=%b exp=1", rd_en);
    end
    wr_en = 1'b1;
    din   = 8'h77;
    repeat (3) @(negedge clk);
    wr_en = 1'b0;
    rx_frame(20, lat, bits, st);
    exp = {1'b1, 8'h3C, 1'b0};
    n_checks++;
    if (lat !== 2) begin
      n_err++; $display("FAIL coll_latency got=%0d exp=2", lat);
    end
    n_checks++;
    if (bits !== exp) begin
      n_err++; $display("FAIL coll_bits got=%b exp=%b", bits, exp);
    end
    n_checks++;
    if (rd_cnt - r0 !== 4) begin
      n_err++; $display("FAIL coll_rd_cycles got=%0d exp=4", rd_cnt - r0);
    end
    n_checks++;
    if (pops - p0 !== 1) begin
      n_err++; $display("FAIL coll_pops got=%0d exp=1", pops - p0);
    end
    exp = {1'b1, 8'h77, 1'b0};
    for (int j = 0; j < 3; j++) begin
      rx_frame(20, lat, bits, st);
      n_checks++;
      if (lat !== 3 || bits !== exp) begin
        n_err++;
        $display("FAIL coll_drain%0d got lat=%0d bits=%b exp lat=3 bits=%b", j, lat, bits, exp);
      end
    end
    enable = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (empty !== 1'b1) begin
      n_err++; $display("FAIL coll_empty got=%b exp=1", empty);
    end
  endtask

  task automatic test_full_pop();
    int lat, r0, bad;
    logic [9:0] bits, exp;
    bit st;
    for (int i = 0; i < 16; i++) push(8'(16 + i));
    n_checks++;
    if (full !== 1'b1) begin
      n_err++; $display("FAIL full_flag got=%b exp=1", full);
    end
    r0 = rd_cnt;
    enable = 1'b1;
    @(negedge clk);
    wr_en = 1'b1;
    din   = 8'hEE;
    @(negedge clk);
    wr_en = 1'b0;
    n_checks++;
    if (rd_en !== 1'b0) begin
      n_err++; $display("FAIL full_no_retry got=%b exp=0", rd_en);
    end
    rx_frame(20, lat, bits, st);
    exp = {1'b1, 8'h10, 1'b0};
    n_checks++;
    if (lat !== 1 || bits !== exp) begin
      n_err++;
      $display("FAIL full_first got lat=%0d bits=%b exp lat=1 bits=%b", lat, bits, exp);
    end
    bad = 0;
    for (int j = 1; j < 16; j++) begin
      exp = {1'b1, 8'(16 + j), 1'b0};
      rx_frame(20, lat, bits, st);
      if (lat !== 3 || bits !== exp) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_err++; $display("FAIL full_drain bad_frames=%0d exp=0", bad);
    end
    enable = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (rd_cnt - r0 !== 16 || empty !== 1'b1) begin
      n_err++;
      $display("FAIL full_rd_cycles got=%0d empty=%b exp=16 empty=1", rd_cnt - r0, empty);
    end
  endtask

  task automatic test_enable_gate();
    int r0, d0, r1, t1;
    bit found;
    push(8'h81); push(8'h82); push(8'h83);
    r0 = rd_cnt; d0 = done_cnt;
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (found !== 1'b1) begin
      n_err++; $display("FAIL gate_start got=%b exp=1", found);
    end
    repeat (12) @(negedge clk);
    enable = 1'b0;
    repeat (27) @(negedge clk);
    r1 = rd_cnt; t1 = tx_lo;
    repeat (60) @(negedge clk);
    n_checks++;
    if (done_cnt - d0 !== 1) begin
      n_err++; $display("FAIL gate_done got=%0d exp=1", done_cnt - d0);
    end
    n_checks++;
    if (rd_cnt - r1 !== 0 || rd_cnt - r0 !== 1) begin
      n_err++;
      $display("FAIL gate_no_pop got after=%0d total=%0d exp 0 1", rd_cnt - r1, rd_cnt - r0);
    end
    n_checks++;
    if (tx_lo - t1 !== 0) begin
      n_err++; $display("FAIL gate_tx_idle got=%0d exp=0", tx_lo - t1);
    end
    n_checks++;
    if (cnt !== 5'd2) begin
      n_err++; $display("FAIL gate_fifo_level got=%0d exp=2", cnt);
    end
  endtask

  task automatic test_reset_mid();
    int lat, p0;
    logic [9:0] bits, exp;
    bit st, found;
    p0 = pops;
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (found !== 1'b1) begin
      n_err++; $display("FAIL rmid_start got=%b exp=1", found);
    end
    repeat (16) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_async got tx=%b busy=%b exp tx=1 busy=0", tx, busy);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    rx_frame(20, lat, bits, st);
    exp = {1'b1, 8'h83, 1'b0};
    n_checks++;
    if (lat !== 3 || bits !== exp) begin
      n_err++;
      $display("FAIL rmid_fresh got lat=%0d bits=%b exp lat=3 bits=%b", lat, bits, exp);
    end
    n_checks++;
    if (pops - p0 !== 2) begin
      n_err++; $display("FAIL rmid_pops got=%0d exp=2", pops - p0);
    end
    @(negedge clk);
    n_checks++;
    if (tx_done !== 1'b1 || empty !== 1'b1) begin
      n_err++;
      $display("FAIL rmid_end got done=%b empty=%b exp 1 1", tx_done, empty);
    end
    enable = 1'b0;
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b0;
    wr_en  = 1'b0;
    din    = '0;
    test_reset();
    test_single();
    test_burst();
    test_collision();
    test_full_pop();
    test_enable_gate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
